// File: rtl/ahb_itcm_slave.sv
// rtl/ahb_itcm_slave.sv - AHB-Lite ITCM slave with power-up clear, wait states and error responses
module ahb_itcm_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [6:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        itcm_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  clr_cnt;
    logic           clearing;
    logic           clear_last;
    logic           dp_valid;
    logic           dp_write;
    logic [AW-1:0]  dp_idx;
    logic [3:0]     dp_lanes;
    logic [1:0]     wait_cnt;
    logic [31:0]    mem [DEPTH];

    logic [32:0]    off;
    logic           addr_err;
    logic           size_err;
    logic           align_err;
    logic           accept;
    logic           acc_err;
    logic [3:0]     acc_lanes;
    logic           unused;

    // A borrow out of the subtraction flags addresses below BASE_ADDR.
    assign off        = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign addr_err   = |off[32:AW+2];
    assign size_err   = (hsize > 3'b010);
    assign align_err  = ((hsize == 3'b001) & haddr[0]) | ((hsize == 3'b010) & (|haddr[1:0]));
    assign accept     = hsel & hready & htrans[1] & hreadyout;
    assign acc_err    = addr_err | size_err | align_err | clearing;
    assign clear_last = clearing & (clr_cnt == AW'(DEPTH - 1));
    assign unused     = ^{htrans[0], hburst, hprot, hmastlock, off[1:0]};

    always_comb begin
        acc_lanes = 4'b0000;
        case (hsize[1:0])
            2'b00:   acc_lanes = 4'b0001 << haddr[1:0];
            2'b01:   acc_lanes = haddr[1] ? 4'b1100 : 4'b0011;
            default: acc_lanes = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                // INIT, IDLE and ERR2 all present hreadyout=1 and can take a new transfer.
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = S_ERR1;
                    end else begin
                        state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
                    end
                end else begin
                    state_nxt = (clearing & ~clear_last) ? S_INIT : S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            state    <= S_INIT;
            clearing <= 1'b1;
            clr_cnt  <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lanes <= 4'b0000;
            wait_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (clearing) begin
                clr_cnt <= clr_cnt + AW'(1);
                if (clear_last) begin
                    clearing <= 1'b0;
                end
            end
            if (accept) begin
                dp_valid <= ~acc_err;
                dp_write <= hwrite;
                dp_idx   <= off[AW+1:2];
                dp_lanes <= acc_lanes;
                wait_cnt <= WS_LOAD;
            end else if (hreadyout) begin
                dp_valid <= 1'b0;
            end else if ((state == S_WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hrstn) begin
            if (clearing) begin
                mem[clr_cnt] <= 32'h0;
            end else if (dp_valid & dp_write & hreadyout) begin
                for (int b = 0; b < 4; b++) begin
                    if (dp_lanes[b]) begin
                        mem[dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign hreadyout  = ~((state == S_WAIT) | (state == S_ERR1));
    assign hresp      = (state == S_ERR1) | (state == S_ERR2);
    assign hrdata     = (dp_valid & ~dp_write) ? mem[dp_idx] : 32'h0;
    assign itcm_ready = ~clearing;

endmodule

// File: doc/ahb_itcm_slave.md
AHB_ITCM_SLAVE -- requirements
Module: ahb_itcm_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit words, power of two.
REQ-003 Parameter WAIT_STATES, default 1, legal range 0..3: data-phase wait cycles per OKAY transfer.
REQ-004 hclk  in  1  clock; all state changes on the rising edge.
REQ-005 hrstn  in  1  reset; one clock, synchronous, active-low.
REQ-006 hsel  in  1  slave select, address phase.
REQ-007 haddr  in  32  byte address, address phase.
REQ-008 htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 hwrite  in  1  1=write, 0=read.
REQ-010 hsize  in  3  000=byte, 001=half, 010=word.
REQ-011 hburst, hprot, hmastlock  in  3/7/1  accepted and ignored.
REQ-012 hwdata  in  32  write data, data phase.
REQ-013 hready  in  1  bus-level ready; qualifies address-phase sampling.
REQ-014 hreadyout  out  1  slave ready; low extends the data phase.
REQ-015 hresp  out  1  0=OKAY, 1=ERROR.
REQ-016 hrdata  out  32  read data; valid when hreadyout=1 on a read data phase.
REQ-017 itcm_ready  out  1  high once memory init is complete.

Function
REQ-018 FSM states: INIT, IDLE, WAIT, ERR1, ERR2.
REQ-019 Address phase accepted when hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize are registered on that edge. BUSY/IDLE transfers are not accepted and receive zero-wait OKAY.
REQ-020 INIT: a clear counter writes 0 to one word per cycle, from 0 to DEPTH-1; itcm_ready=0 and hreadyout=1 throughout; exit to IDLE on the cycle after word DEPTH-1 is written; itcm_ready=1 from that cycle onward.
REQ-021 Any transfer accepted in INIT is an error transfer (REQ-024); the clear sequence continues unaffected.
REQ-022 Error conditions, evaluated at acceptance: haddr outside [BASE_ADDR, BASE_ADDR+4*DEPTH); hsize>010; misalignment (half with haddr[0]=1, word with haddr[1:0]!=00).
REQ-023 Legal transfer: WAIT_STATES>0 -> enter WAIT with hreadyout=0 for exactly WAIT_STATES cycles, then one cycle with hreadyout=1 and hresp=0; WAIT_STATES=0 -> hreadyout=1 in the first data-phase cycle.
REQ-024 Error transfer: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); no memory write; hrdata=0.
REQ-025 Write commit: on the edge that ends the data phase (hreadyout=1), only the addressed byte lanes of word (haddr-BASE_ADDR)>>2 are updated from the matching hwdata lanes.
REQ-026 Read: hrdata = stored word at the registered index; all 4 lanes driven, no lane masking; hrdata=0 when not in a read data phase.
REQ-027 Pipelining: a new address phase accepted on the data-phase completion edge of the previous transfer starts its data phase in the next cycle with no gap.
REQ-028 Read immediately following a write to the same word returns the newly written data.
REQ-029 Address phases presented while hreadyout=0 are ignored; hready=0 blocks acceptance.

Reset
REQ-030 hrstn=0 sampled on an edge -> state INIT, clear counter 0, hreadyout=1, hresp=0, hrdata=0, itcm_ready=0; any in-flight transfer is dropped without a memory write.
REQ-031 Reset held for N cycles keeps all outputs at their reset values; the clear sequence starts on the first edge with hrstn=1.

Verification
REQ-032 Reset release, DEPTH=16 -> itcm_ready=0 for 16 cycles, then 1; a read of every word returns 32'h0.
REQ-033 WAIT_STATES=2, word write 32'hDEAD_BEEF to BASE+8, then read BASE+8 -> each transfer has 2 cycles hreadyout=0 followed by OKAY; read returns 32'hDEAD_BEEF.
REQ-034 Byte write 8'hA5 to BASE+5 over a word of 0 -> read of BASE+4 returns 32'h0000_A500.
REQ-035 Read at BASE+4*DEPTH, then word read at BASE+2 -> each gets ERR1/ERR2 (hresp=1 for 2 cycles, hreadyout 0 then 1); memory unchanged.
REQ-036 WAIT_STATES=0, back-to-back NONSEQ write BASE+0=1 then read BASE+0 -> no wait cycles; read returns 1.
REQ-037 hrstn=0 asserted during WAIT of a write -> write not committed; itcm_ready=0 and hreadyout=1 on the next cycle.
